// File: rtl/seq_mult_nxn.sv
// Sequential shift-add WIDTH x WIDTH multiplier with busy flag, one-cycle done pulse and back-to-back starts.
// Optional two's-complement mode is compiled in when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_nxn #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     mcand_d;
    logic [WIDTH-1:0]  mplier_q;
    logic [WIDTH-1:0]  mplier_d;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              busy_d;
    logic              done_d;
    logic [PW-1:0]     product_d;

    logic              accept_c;
    logic [WIDTH-1:0]  mag_a_c;
    logic [WIDTH-1:0]  mag_b_c;
    logic [PW-1:0]     sum_c;
    logic [PW-1:0]     result_c;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_c;
    logic neg_q;

    // Magnitudes are taken at capture; -2^(WIDTH-1) negates to itself, which reads as 2^(WIDTH-1) unsigned.
    always_comb begin
        neg_c   = 1'b0;
        mag_a_c = dataa;
        mag_b_c = datab;
        if (signed_mode) begin
            neg_c = dataa[WIDTH-1] ^ datab[WIDTH-1];
            if (dataa[WIDTH-1]) begin
                mag_a_c = -dataa;
            end
            if (datab[WIDTH-1]) begin
                mag_b_c = -datab;
            end
        end
    end

    assign result_c = neg_q ? -sum_c : sum_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (accept_c) begin
            neg_q <= neg_c;
        end
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign mag_a_c            = dataa;
    assign mag_b_c            = datab;
    assign result_c           = sum_c;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy;
        done_d    = 1'b0;
        product_d = product;
        accept_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept_c = start;
            end
            CALC: begin
                acc_d    = sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = result_c;
                end
            end
            DONE: begin
                accept_c = start;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A start in IDLE or DONE captures fresh operands; the DONE case gives back-to-back throughput.
        if (accept_c) begin
            state_d  = CALC;
            busy_d   = 1'b1;
            mcand_d  = PW'(mag_a_c);
            mplier_d = mag_b_c;
            acc_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            product  <= product_d;
        end
    end

endmodule
